// File: rtl/sorted_loader_pkg.sv
// Shared defaults and FSM state encoding for the sorted-array loader.
package sorted_loader_pkg;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CMP,
        PLACE
    } state_t;
endpackage

// File: rtl/sorted_loader_ctrl.sv
// Insertion FSM: walks the hole down from the top of the sorted prefix and
// produces the RAM write enable plus address/data mux selects for the top.
module sorted_loader_ctrl
    import sorted_loader_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,          // accepted transfer into a non-full array
    input  logic empty,          // count == 0 at the time of the transfer
    input  logic gt,             // ram_q > val
    input  logic hole_at_one,    // idx == 1, so this shift reaches slot 0
    output logic idle,
    output logic busy,
    output logic shift,
    output logic place,
    output logic ram_wren,
    output logic sel_addr_m1,
    output logic sel_addr_hole,
    output logic sel_data_q,
    output logic sel_data_val
);
    state_t state, next_state;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state    = state;
        ram_wren      = 1'b0;
        sel_addr_m1   = 1'b0;
        sel_addr_hole = 1'b0;
        sel_data_q    = 1'b0;
        sel_data_val  = 1'b0;
        shift         = 1'b0;
        place         = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = empty ? PLACE : READ;
            end
            READ: begin
                sel_addr_m1 = 1'b1;
                next_state  = CMP;
            end
            CMP: begin
                if (gt) begin
                    // Move the larger neighbour up into the hole.
                    sel_addr_hole = 1'b1;
                    sel_data_q    = 1'b1;
                    ram_wren      = 1'b1;
                    shift         = 1'b1;
                    next_state    = hole_at_one ? PLACE : READ;
                end else begin
                    next_state = PLACE;
                end
            end
            PLACE: begin
                sel_addr_hole = 1'b1;
                sel_data_val  = 1'b1;
                ram_wren      = 1'b1;
                place         = 1'b1;
                next_state    = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign idle = (state == IDLE);
    assign busy = (state != IDLE);
endmodule

// File: rtl/sorted_array_loader.sv
// Insertion-sort writer for the sorted-array RAM shared with the searcher.
// Optional feature: define SORTED_LOADER_OVF_EN to drop inserts into a full
// array and raise the sticky ovf flag instead of back-pressuring.
module sorted_array_loader #(
    parameter int DEPTH = sorted_loader_pkg::DEPTH_DEF,
    parameter int AW    = sorted_loader_pkg::AW_DEF,
    parameter int DW    = sorted_loader_pkg::DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          clear,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic [AW:0]   count,
    output logic          full,
    output logic          busy,
    output logic          ovf
);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] val;
    logic [AW:0]   idx;
    logic [AW:0]   hole_m1;
    logic          idle, shift, place, start, xfer, clear_ok;
    logic          sel_addr_m1, sel_addr_hole, sel_data_q, sel_data_val;

    assign full     = (count == FULL_COUNT);
`ifdef SORTED_LOADER_OVF_EN
    assign in_ready = idle;
`else
    assign in_ready = idle && !full;
`endif
    assign xfer     = in_valid && in_ready;
    assign start    = xfer && !full;
    assign clear_ok = idle && clear && !xfer;
    // Only consumed in READ/CMP, where idx >= 1 always holds.
    assign hole_m1  = idx - 1'b1;

    sorted_loader_ctrl u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .empty        (count == '0),
        .gt           (ram_q > val),
        .hole_at_one  (idx == (AW + 1)'(1)),
        .idle         (idle),
        .busy         (busy),
        .shift        (shift),
        .place        (place),
        .ram_wren     (ram_wren),
        .sel_addr_m1  (sel_addr_m1),
        .sel_addr_hole(sel_addr_hole),
        .sel_data_q   (sel_data_q),
        .sel_data_val (sel_data_val)
    );

    assign ram_addr = sel_addr_m1   ? hole_m1[AW-1:0] :
                      sel_addr_hole ? idx[AW-1:0]     : '0;
    assign ram_data = sel_data_q    ? ram_q :
                      sel_data_val  ? val   : '0;

    // NOTE: the RAM itself is never reset or wiped; count alone defines
    // which prefix of it is meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            val   <= '0;
            idx   <= '0;
        end else begin
            if (start) begin
                val <= in_data;
                idx <= count;
            end else if (clear_ok) begin
                count <= '0;
            end
            if (shift) idx   <= hole_m1;
            if (place) count <= count + 1'b1;
        end
    end

`ifdef SORTED_LOADER_OVF_EN
    logic ovf_r;
    always_ff @(posedge clk) begin
        if (reset)              ovf_r <= 1'b0;
        else if (xfer && full)  ovf_r <= 1'b1;
        else if (clear_ok)      ovf_r <= 1'b0;
    end
    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_sorted_array_loader.sv
// Scoreboard bench for sorted_array_loader: a sorted-queue model predicts
// latency, count, ovf and RAM prefix; a negedge monitor checks completions.
module tb_sorted_array_loader;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 8;

    typedef struct packed {
        logic [6:0]                  lat;
        logic [AW:0]                 cnt;
        logic                        ovf;
        logic [DEPTH-1:0][DW-1:0]    arr;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          clear = 1'b0;
    logic          in_ready, ram_wren, full, busy, ovf;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
    logic [AW:0]   count;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] model [$];
    logic          ovf_m = 1'b0;
    exp_t          scb [$];
    int            n_checks = 0;
    int            n_pass = 0;

    sorted_array_loader dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .count(count), .full(full), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM the loader drives.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Predict one insertion from the sorted model and queue the expectation.
    task automatic expect_insert(input logic [DW-1:0] v);
        exp_t e;
        int   n, p, k;
        e = '0;
        n = model.size();
        if (n == DEPTH) begin
            ovf_m = 1'b1;
            e.lat = 7'd0;
            e.cnt = (AW + 1)'(n);
        end else begin
            p = 0;
            foreach (model[i]) if (model[i] <= v) p++;
            k = n - p;
            if (n == 0)      e.lat = 7'd1;
            else if (k == 0) e.lat = 7'd3;
            else if (p == 0) e.lat = 7'(2 * k + 1);
            else             e.lat = 7'(2 * k + 3);
            model.insert(p, v);
            e.cnt = (AW + 1)'(n + 1);
        end
        e.ovf = ovf_m;
        for (int i = 0; i < DEPTH; i++) e.arr[i] = (i < model.size()) ? model[i] : '0;
        scb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) check(name, 32'(busy), 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 with the DUT idle.
    task automatic insert(input logic [DW-1:0] v, input bit with_clear = 1'b0);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        expect_insert(v);
        in_data  = v;
        in_valid = 1'b1;
        clear    = with_clear;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        wait_idle("insert_timeout");
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model.delete();
        ovf_m = 1'b0;
        check("clear_count", 32'(count), 32'd0);
        check("clear_ovf", 32'(ovf), 32'd0);
    endtask

    // Monitor: time each transfer to its return to IDLE and compare.
    initial begin
        bit   tracking;
        int   lat;
        exp_t e;
        tracking = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                tracking = 1'b0;
                scb.delete();
                continue;
            end
            if (tracking) begin
                if (busy) begin
                    lat++;
                    if (lat > 80) begin
                        check("busy_timeout", 32'(lat), 32'd0);
                        tracking = 1'b0;
                    end
                end else begin
                    tracking = 1'b0;
                    if (scb.size() == 0) begin
                        check("scb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = scb.pop_front();
                        check("latency", 32'(lat), 32'(e.lat));
                        check("count", 32'(count), 32'(e.cnt));
                        check("ovf", 32'(ovf), 32'(e.ovf));
                        for (int i = 0; i < DEPTH; i++)
                            if (i < int'(e.cnt))
                                check($sformatf("ram[%0d]", i), 32'(mem[i]), 32'(e.arr[i]));
                    end
                end
            end
            if (!tracking && in_valid && in_ready) begin
                tracking = 1'b1;
                lat = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ram_wren", 32'(ram_wren), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_data", 32'(ram_data), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Directed sequence including the stable duplicate.
        insert(8'h40);
        insert(8'h50);
        insert(8'h10);
        insert(8'h30);
        insert(8'h30);
        check("dup_slot2", 32'(mem[2]), 32'h30);

        // Fill with descending values: every insert shifts to slot 0.
        do_clear();
        for (int i = 0; i < DEPTH; i++) insert(8'(8'hFF - i));
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd32);
`ifdef SORTED_LOADER_OVF_EN
        check("full_ready_ovf", 32'(in_ready), 32'd1);
        insert(8'h00);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_count", 32'(count), 32'd32);
`else
        in_data  = 8'h00;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("stall_ready", 32'(in_ready), 32'd0);
        check("stall_count", 32'(count), 32'd32);
        check("stall_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
`endif

        // clear while busy is held off until IDLE.
        do_clear();
        insert(8'h20);
        insert(8'h30);
        insert(8'h40);
        expect_insert(8'h05);
        in_data  = 8'h05;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear    = 1'b1;
        wait_idle("clear_busy_timeout");
        check("clear_held_count", 32'(count), 32'd4);
        @(posedge clk); #1;
        clear = 1'b0;
        model.delete();
        check("clear_after_busy", 32'(count), 32'd0);

        // clear and a transfer together in IDLE: transfer wins.
        insert(8'h11);
        insert(8'h22, 1'b1);
        check("xfer_beats_clear", 32'(count), 32'd2);

        // Reset during the third shift abandons the insertion.
        do_clear();
        insert(8'h10);
        insert(8'h20);
        insert(8'h30);
        insert(8'h40);
        in_data  = 8'h01;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("third_shift_wren", 32'(ram_wren), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model.delete();
        ovf_m = 1'b0;
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_count", 32'(count), 32'd0);
        check("mid_reset_ready", 32'(in_ready), 32'd1);
        insert(8'h07);

        // Randomized inserts with small-value duplicates and sporadic clears.
        do_clear();
        repeat (60) begin
            if (model.size() == DEPTH || $urandom_range(0, 15) == 0) do_clear();
            v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            insert(v, $urandom_range(0, 7) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scb_drained", 32'(scb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
